// File: rtl/riscv_pkg.sv
// Shared encodings and types for the RV32I memory stage: funct3 load/store codes,
// result-select encodings, FSM state, hold/writeback record layouts and store-lane helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  typedef enum logic [0:0] {IDLE, WAIT} state_e;

  // One in-flight memory instruction, already reduced to bus-ready lanes.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
  } hold_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pcplus4;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif
  } wb_t;

  // Misaligned offsets are truncated to the access size rather than rejected.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   store_wdata = {4{w[7:0]}};
      2'b01:   store_wdata = {2{w[15:0]}};
      default: store_wdata = w;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half lane of a read word and
// sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_BU:   data = {24'b0, byte_lane};
      F3_HU:   data = {16'b0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: data-memory req/ready handshake, stall generation and MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN suppresses misaligned H/W accesses and adds misalignW.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_resultM,
  input  logic [31:0] w_dataM,
  input  logic [4:0]  rdM,
  input  logic [31:0] pcplus4M,
  input  logic        reg_writeM,
  input  logic        mem_writeM,
  input  logic [1:0]  result_srcM,
  input  logic [2:0]  funct3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_mem,
  output logic [31:0] ALU_resultW,
  output logic [31:0] read_dataW,
  output logic [4:0]  rdW,
  output logic [31:0] pcplus4W,
  output logic        reg_writeW,
  output logic [1:0]  result_srcW,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalignW,
`endif
  output logic        bus_errW
);

  localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  hold_t           m_txn, cur, hold_q, hold_d;
  wb_t             wb_ret, wb_q, wb_d;
  logic [31:0]     load_data;
  logic            access, mis_trap, timeout, cur_is_load;

  always_comb begin
    m_txn.alu_result = ALU_resultM;
    m_txn.wdata      = store_wdata(funct3M, w_dataM);
    m_txn.be         = store_be(funct3M, ALU_resultM[1:0]);
    m_txn.we         = mem_writeM;
    m_txn.rd         = rdM;
    m_txn.pcplus4    = pcplus4M;
    m_txn.reg_write  = reg_writeM;
    m_txn.result_src = result_srcM;
    m_txn.funct3     = funct3M;
  end

  assign access = mem_writeM | (result_srcM == RESULT_LOAD);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_trap = access & (((funct3M[1:0] == 2'b01) & ALU_resultM[0]) |
                              ((funct3M[1:0] == 2'b10) & (ALU_resultM[1:0] != 2'b00)));
`else
  assign mis_trap = 1'b0;
`endif

  // While waiting, the bus and the retiring instruction come only from the hold registers.
  assign cur         = (state_q == WAIT) ? hold_q : m_txn;
  assign cur_is_load = (cur.result_src == RESULT_LOAD) & ~cur.we;
  assign timeout     = (state_q == WAIT) & ~dmem_ready & (WAIT_LIMIT != 0) &
                       (wait_cnt_q == CntW'(WAIT_LIMIT));

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (cur.alu_result[1:0]),
    .funct3 (cur.funct3),
    .data   (load_data)
  );

  always_comb begin
    wb_ret            = '0;
    wb_ret.alu_result = cur.alu_result;
    wb_ret.read_data  = cur_is_load ? load_data : 32'b0;
    wb_ret.rd         = cur.rd;
    wb_ret.pcplus4    = cur.pcplus4;
    wb_ret.reg_write  = cur.reg_write;
    wb_ret.result_src = cur.result_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      hold_q     <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
      wb_q       <= wb_d;
    end
  end

  // wb_d defaults to a bubble; only completing (or failing) instructions overwrite it.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hold_d     = hold_q;
    wb_d       = '0;
    unique case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (!access || dmem_ready || mis_trap) begin
          wb_d = wb_ret;
          if (mis_trap) begin
            wb_d.reg_write = 1'b0;
            wb_d.read_data = '0;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_d.misalign  = 1'b1;
`endif
          end
        end else begin
          hold_d     = m_txn;
          wait_cnt_d = CntW'(1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          wb_d    = wb_ret;
          state_d = IDLE;
        end else if (timeout) begin
          wb_d           = wb_ret;
          wb_d.reg_write = 1'b0;
          wb_d.read_data = '0;
          wb_d.bus_err   = 1'b1;
          state_d        = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = 1'b0;
    stall_mem = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          dmem_req  = access & ~mis_trap;
          stall_mem = access & ~mis_trap & ~dmem_ready;
        end
        WAIT: begin
          dmem_req  = ~timeout;
          stall_mem = ~timeout & ~dmem_ready;
        end
        default: ;
      endcase
    end
    dmem_we    = dmem_req & cur.we;
    dmem_addr  = {cur.alu_result[31:2], 2'b00};
    dmem_wdata = cur.wdata;
    dmem_be    = cur.be;
  end

  assign ALU_resultW = wb_q.alu_result;
  assign read_dataW  = wb_q.read_data;
  assign rdW         = wb_q.rd;
  assign pcplus4W    = wb_q.pcplus4;
  assign reg_writeW  = wb_q.reg_write;
  assign result_srcW = wb_q.result_src;
  assign bus_errW    = wb_q.bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalignW   = wb_q.misalign;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized load/store/ALU traffic
// checked against an arithmetic reference model of lane selection and extension.
module tb_mem_stage;

  localparam int unsigned WaitLimit = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_resultM, w_dataM, pcplus4M, dmem_rdata;
  logic [4:0]  rdM;
  logic        reg_writeM, mem_writeM, dmem_ready;
  logic [1:0]  result_srcM;
  logic [2:0]  funct3M;
  logic        dmem_req, dmem_we, stall_mem, reg_writeW, bus_errW;
  logic [31:0] dmem_addr, dmem_wdata, ALU_resultW, read_dataW, pcplus4W;
  logic [3:0]  dmem_be;
  logic [4:0]  rdW;
  logic [1:0]  result_srcW;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalignW;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_stage #(.WAIT_LIMIT(WaitLimit)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALU_resultM (ALU_resultM),
    .w_dataM     (w_dataM),
    .rdM         (rdM),
    .pcplus4M    (pcplus4M),
    .reg_writeM  (reg_writeM),
    .mem_writeM  (mem_writeM),
    .result_srcM (result_srcM),
    .funct3M     (funct3M),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .stall_mem   (stall_mem),
    .ALU_resultW (ALU_resultW),
    .read_dataW  (read_dataW),
    .rdW         (rdW),
    .pcplus4W    (pcplus4W),
    .reg_writeW  (reg_writeW),
    .result_srcW (result_srcW),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalignW   (misalignW),
`endif
    .bus_errW    (bus_errW)
  );

  // Reference model: byte lanes and extension computed with plain shifts and arithmetic.
  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = 32'(a[1:0]);
    if (f3[1:0] == 2'b00) return 4'(1 << off);
    if (f3[1:0] == 2'b01) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
    int unsigned v;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (r >> (8 * 32'(a[1:0]))) & 32'hFF;
      if (f3 == 3'b000 && v >= 128) v = v - 256;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      v = (r >> (16 * 32'(a[1]))) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  task automatic drive_nop();
    ALU_resultM = $urandom; w_dataM = $urandom; rdM = 5'($urandom); pcplus4M = $urandom;
    reg_writeM = 1'b0; mem_writeM = 1'b0; result_srcM = 2'b00; funct3M = 3'($urandom);
  endtask

  task automatic scramble_m();
    ALU_resultM = $urandom; w_dataM = $urandom; rdM = 5'($urandom); pcplus4M = $urandom;
    reg_writeM = 1'($urandom); mem_writeM = 1'($urandom); result_srcM = 2'($urandom);
    funct3M = 3'($urandom);
  endtask

  // Presents one instruction at a negedge; memory answers after nwait stalled cycles.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int nwait,
                         input logic [4:0] rd, input logic [31:0] pc4, input logic [1:0] rsrc,
                         input logic rw);
    logic acc, ld;
    acc = st | (rsrc == 2'b01);
    ld  = (rsrc == 2'b01) & ~st;
    ALU_resultM = addr; w_dataM = wd; rdM = rd; pcplus4M = pc4; reg_writeM = rw;
    mem_writeM = st; result_srcM = rsrc; funct3M = f3;
    for (int c = 0; c <= nwait; c++) begin
      dmem_ready = (c == nwait);
      dmem_rdata = (c == nwait) ? rdata : $urandom;
      #1;
      n_total++; if (dmem_req !== acc) $display("FAIL req: got %b exp %b", dmem_req, acc);
      else n_pass++;
      n_total++;
      if (stall_mem !== (acc && c != nwait))
        $display("FAIL stall c=%0d: got %b exp %b", c, stall_mem, acc && c != nwait);
      else n_pass++;
      if (acc) begin
        n_total++;
        if (dmem_addr !== {addr[31:2], 2'b00})
          $display("FAIL addr: got %h exp %h", dmem_addr, {addr[31:2], 2'b00});
        else n_pass++;
        n_total++; if (dmem_we !== st) $display("FAIL we: got %b exp %b", dmem_we, st);
        else n_pass++;
        if (st) begin
          n_total++;
          if (dmem_be !== ref_be(f3, addr))
            $display("FAIL be: got %b exp %b", dmem_be, ref_be(f3, addr));
          else n_pass++;
          n_total++;
          if (dmem_wdata !== ref_wdata(f3, wd))
            $display("FAIL wdata: got %h exp %h", dmem_wdata, ref_wdata(f3, wd));
          else n_pass++;
        end
      end
      @(posedge clk); #1;
      if (c != nwait) begin
        n_total++;
        if (reg_writeW !== 1'b0) $display("FAIL bubble: got reg_writeW %b exp 0", reg_writeW);
        else n_pass++;
        @(negedge clk);
        scramble_m();
      end
    end
    n_total++;
    if (ALU_resultW !== addr) $display("FAIL alu_w: got %h exp %h", ALU_resultW, addr);
    else n_pass++;
    n_total++; if (rdW !== rd) $display("FAIL rd_w: got %h exp %h", rdW, rd); else n_pass++;
    n_total++;
    if (pcplus4W !== pc4) $display("FAIL pc4_w: got %h exp %h", pcplus4W, pc4); else n_pass++;
    n_total++;
    if (reg_writeW !== rw) $display("FAIL rw_w: got %b exp %b", reg_writeW, rw); else n_pass++;
    n_total++;
    if (result_srcW !== rsrc) $display("FAIL rsrc_w: got %b exp %b", result_srcW, rsrc);
    else n_pass++;
    n_total++; if (bus_errW !== 1'b0) $display("FAIL buserr_w: got %b exp 0", bus_errW);
    else n_pass++;
    if (ld || st) begin
      n_total++;
      if (read_dataW !== (ld ? ref_load(f3, addr, rdata) : 32'h0))
        $display("FAIL rdata_w f3=%0d addr=%h: got %h exp %h", f3, addr, read_dataW,
                 ld ? ref_load(f3, addr, rdata) : 32'h0);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_nop(); dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (dmem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", dmem_req);
    else n_pass++;
    n_total++; if (stall_mem !== 1'b0) $display("FAIL rst_stall: got %b exp 0", stall_mem);
    else n_pass++;
    n_total++;
    if ({ALU_resultW, read_dataW, rdW, pcplus4W, reg_writeW, result_srcW, bus_errW} !== '0)
      $display("FAIL rst_w: got %h/%h/%h/%h/%b/%b/%b exp all 0", ALU_resultW, read_dataW,
               rdW, pcplus4W, reg_writeW, result_srcW, bus_errW);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_lb();
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0, 5'd5, 32'h1004, 2'b01, 1'b1);
  endtask

  task automatic test_sh_wait();
    run_txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 3, 5'd0, 32'h2008, 2'b00, 1'b0);
  endtask

  task automatic test_timeout();
    ALU_resultM = 32'h40; rdM = 5'd9; pcplus4M = 32'h3000; reg_writeM = 1'b1;
    mem_writeM = 1'b0; result_srcM = 2'b01; funct3M = 3'b010; dmem_ready = 1'b0;
    for (int c = 0; c <= int'(WaitLimit); c++) begin
      dmem_rdata = $urandom;
      #1;
      n_total++;
      if (dmem_req !== (c < int'(WaitLimit)))
        $display("FAIL to_req c=%0d: got %b exp %b", c, dmem_req, c < int'(WaitLimit));
      else n_pass++;
      n_total++;
      if (stall_mem !== (c < int'(WaitLimit)))
        $display("FAIL to_stall c=%0d: got %b exp %b", c, stall_mem, c < int'(WaitLimit));
      else n_pass++;
      @(posedge clk); #1;
      if (c < int'(WaitLimit)) begin
        n_total++;
        if (reg_writeW !== 1'b0 || bus_errW !== 1'b0)
          $display("FAIL to_bubble c=%0d: got rw %b err %b exp 0 0", c, reg_writeW, bus_errW);
        else n_pass++;
        @(negedge clk);
        scramble_m();
      end
    end
    n_total++; if (bus_errW !== 1'b1) $display("FAIL to_err: got %b exp 1", bus_errW);
    else n_pass++;
    n_total++; if (reg_writeW !== 1'b0) $display("FAIL to_rw: got %b exp 0", reg_writeW);
    else n_pass++;
    n_total++;
    if (ALU_resultW !== 32'h40 || rdW !== 5'd9)
      $display("FAIL to_instr: got %h/%0d exp 00000040/9", ALU_resultW, rdW);
    else n_pass++;
    @(negedge clk);
    drive_nop();
    #1;
    n_total++; if (stall_mem !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL to_idle: got stall %b req %b exp 0 0", stall_mem, dmem_req);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus_errW !== 1'b0) $display("FAIL to_err_pulse: got %b exp 0", bus_errW);
    else n_pass++;
    @(negedge clk);
    run_txn(1'b0, 3'b100, 32'h41, 32'h0, 32'hAABB_CC99, 0, 5'd3, 32'h3004, 2'b01, 1'b1);
  endtask

  task automatic test_reset_wait();
    ALU_resultM = 32'h80; rdM = 5'd7; pcplus4M = 32'h4000; reg_writeM = 1'b1;
    mem_writeM = 1'b0; result_srcM = 2'b01; funct3M = 3'b010; dmem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      scramble_m();
    end
    rst = 1'b1; drive_nop();
    @(posedge clk); #1;
    n_total++; if (reg_writeW !== 1'b0) $display("FAIL rw_rst: got %b exp 0", reg_writeW);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (dmem_req !== 1'b0) $display("FAIL req_after_rst: got %b exp 0", dmem_req);
    else n_pass++;
    n_total++;
    if (stall_mem !== 1'b0) $display("FAIL stall_after_rst: got %b exp 0", stall_mem);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (reg_writeW !== 1'b0) $display("FAIL no_w_write: got %b exp 0", reg_writeW);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic random_txn(input int max_wait);
    logic [2:0]  load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [1:0]  alu_src [3] = '{2'b00, 2'b10, 2'b11};
    logic [31:0] addr = $urandom;
    logic [2:0]  f3;
    int          kind = int'($urandom_range(2));
    int          nwait = int'($urandom_range(max_wait));
    if (kind == 1) f3 = load_f3[$urandom_range(4)];
    else if (kind == 2) f3 = 3'($urandom_range(2));
    else f3 = 3'($urandom);
`ifdef MEM_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) addr[0] = 1'b0;
    if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
`endif
    if (kind == 0)
      run_txn(1'b0, f3, addr, $urandom, $urandom, 0, 5'($urandom), $urandom,
              alu_src[$urandom_range(2)], 1'($urandom));
    else if (kind == 1)
      run_txn(1'b0, f3, addr, $urandom, $urandom, nwait, 5'($urandom), $urandom, 2'b01,
              1'b1);
    else
      run_txn(1'b1, f3, addr, $urandom, $urandom, nwait, 5'($urandom), $urandom, 2'b00,
              1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) random_txn(4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) random_txn(0);
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    ALU_resultM = 32'h6; w_dataM = $urandom; rdM = 5'd0; pcplus4M = 32'h5000;
    reg_writeM = 1'b0; mem_writeM = 1'b1; result_srcM = 2'b00; funct3M = 3'b010;
    dmem_ready = 1'b0;
    #1;
    n_total++; if (dmem_req !== 1'b0) $display("FAIL mis_req: got %b exp 0", dmem_req);
    else n_pass++;
    n_total++; if (stall_mem !== 1'b0) $display("FAIL mis_stall: got %b exp 0", stall_mem);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (misalignW !== 1'b1) $display("FAIL mis_flag: got %b exp 1", misalignW);
    else n_pass++;
    n_total++; if (reg_writeW !== 1'b0) $display("FAIL mis_rw: got %b exp 0", reg_writeW);
    else n_pass++;
    @(negedge clk);
    drive_nop();
    @(posedge clk); #1;
    n_total++; if (misalignW !== 1'b0) $display("FAIL mis_pulse: got %b exp 0", misalignW);
    else n_pass++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_lb();
    test_sh_wait();
    test_timeout();
    test_reset_wait();
    test_random();
    test_back_to_back();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
